rom_arbiter: RTL and testbench

Single-cycle arbiter that shares the core's single-port instruction ROM between the instruction-fetch port and the load/store data port. It sits between the fetch stage, the LSU and the ROM wrapper inside the core. Each cycle it grants at most one requester, drives the ROM address and enable, and returns the one-cycle-latency read data to the winner. A bounded-wait guard prevents fetch starvation under back-to-back loads.

---
 rtl/rom_arbiter_if.sv | 51 +++++
 rtl/rom_arbiter.sv | 140 ++++++++++++++
 tb/tb_rom_arbiter.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/rom_arbiter_if.sv
// rom_arbiter_if -- bundle between the ROM arbiter, its two requesters
// (instruction fetch "if_*", load/store "ls_*") and the ROM wrapper ("rom_*").
//
// Parameters: AW = ROM word-address width, DW = data width.
//
// Request/grant semantics:
//   xx_req is a per-cycle request. xx_gnt is the combinational answer for the
//   same cycle. A request counts as accepted only in a cycle where req and gnt
//   are both high. A denied requester simply presents the request again; the
//   arbiter keeps no copy of a denied address. rom_ce/rom_addr drive the ROM
//   in the grant cycle. rom_rdata comes back one cycle later and appears on
//   the winner's xx_rdata qualified by xx_rvalid. There is no backpressure on
//   the return path.
//
// Modports:
//   slave  -- the arbiter side (requests and ROM data in, grants/data/ROM ctrl out)
//   master -- the environment side (fetch, LSU and ROM wrapper)
interface rom_arbiter_if #(
  parameter int AW = 12,
  parameter int DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;

  logic          ls_req;
  logic [AW-1:0] ls_addr;
  logic          ls_gnt;
  logic          ls_rvalid;
  logic [DW-1:0] ls_rdata;

  logic          rom_ce;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_rdata;

  modport slave (
    input  if_req, if_addr, ls_req, ls_addr, rom_rdata,
    output if_gnt, if_rvalid, if_rdata,
    output ls_gnt, ls_rvalid, ls_rdata,
    output rom_ce, rom_addr
  );

  modport master (
    output if_req, if_addr, ls_req, ls_addr, rom_rdata,
    input  if_gnt, if_rvalid, if_rdata,
    input  ls_gnt, ls_rvalid, ls_rdata,
    input  rom_ce, rom_addr
  );
endinterface

// File: rtl/rom_arbiter.sv
// rom_arbiter -- shares the single-port instruction ROM between instruction
// fetch and the load/store data port. At most one grant per cycle. The ROM
// read data (one-cycle latency) is steered back to whichever port won the
// previous cycle.
//
// Ports:
//   clk        core clock, all state on the rising edge
//   rst        asynchronous, active-high reset
//   bus        rom_arbiter_if.slave: fetch port, load port, ROM port
//   dbg_owner  owner_q state (0 = NONE, 1 = IF, 2 = LS)
//   dbg_wait   starvation counter wait_q (always 0 when the guard is not built)
//
// Parameters:
//   AW, DW     address / data width. Must match the interface instance.
//   MAX_WAIT   consecutive denied fetch cycles before fetch is forced to win (1..15)
//
// Build option:
//   ROM_ARB_STARVE_GUARD_EN  when defined, the starvation counter and guard are
//                            built. When undefined, priority is strictly ls > if,
//                            so a continuous ls_req can starve fetch and MAX_WAIT
//                            has no effect.
//
// Grants, rom_ce and rom_addr are purely combinational from the requests and
// registered state, so they follow the requests even while rst is held. Data is
// still discarded during reset because owner_q is forced to NONE.
module rom_arbiter #(
  parameter int AW       = 12,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic         clk,
  input  logic         rst,
  rom_arbiter_if.slave bus,
  output logic [1:0]   dbg_owner,
  output logic [3:0]   dbg_wait
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LS   = 2'd2
  } owner_t;

  // Catch an out-of-range MAX_WAIT at elaboration. wait_q is only 4 bits wide.
  if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_bad_max_wait
    $error("rom_arbiter: MAX_WAIT=%0d outside 1..15", MAX_WAIT);
  end

  owner_t owner_q, owner_d;
  logic   if_gnt_c, ls_gnt_c;
  logic   guard_fire;

`ifdef ROM_ARB_STARVE_GUARD_EN
  localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

  logic [3:0] wait_q, wait_d;

  // Fetch has now been denied WAIT_LIMIT times in a row, so this collision
  // goes to fetch.
  assign guard_fire = bus.if_req && bus.ls_req && (wait_q == WAIT_LIMIT);
`else
  assign guard_fire = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q <= OWN_NONE;
`ifdef ROM_ARB_STARVE_GUARD_EN
      wait_q  <= 4'd0;
`endif
    end else begin
      owner_q <= owner_d;
`ifdef ROM_ARB_STARVE_GUARD_EN
      wait_q  <= wait_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Arbitration and next state
  // ---------------------------------------------------------------------------
  always_comb begin
    if_gnt_c = 1'b0;
    ls_gnt_c = 1'b0;
    owner_d  = OWN_NONE;

    // Load has priority. When the guard fires, fetch is known to be
    // requesting, so it takes the slot.
    if (bus.ls_req && !guard_fire) begin
      ls_gnt_c = 1'b1;
      owner_d  = OWN_LS;
    end else if (bus.if_req) begin
      if_gnt_c = 1'b1;
      owner_d  = OWN_IF;
    end

`ifdef ROM_ARB_STARVE_GUARD_EN
    wait_d = 4'd0;
    if (bus.if_req && !if_gnt_c) begin
      // Saturation is defensive. At the limit the guard already grants fetch.
      wait_d = (wait_q == WAIT_LIMIT) ? wait_q : wait_q + 4'd1;
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.if_gnt = if_gnt_c;
    bus.ls_gnt = ls_gnt_c;
    bus.rom_ce = if_gnt_c | ls_gnt_c;

    bus.rom_addr = '0;
    if (ls_gnt_c) begin
      bus.rom_addr = bus.ls_addr;
    end else if (if_gnt_c) begin
      bus.rom_addr = bus.if_addr;
    end

    bus.if_rvalid = (owner_q == OWN_IF);
    bus.ls_rvalid = (owner_q == OWN_LS);

    // The data bus of a port that did not own the previous slot is forced to
    // zero, so the other port's data never shows on it.
    bus.if_rdata = (owner_q == OWN_IF) ? bus.rom_rdata : '0;
    bus.ls_rdata = (owner_q == OWN_LS) ? bus.rom_rdata : '0;

    dbg_owner = owner_q;
`ifdef ROM_ARB_STARVE_GUARD_EN
    dbg_wait  = wait_q;
`else
    dbg_wait  = 4'd0;
`endif
  end

endmodule

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter -- directed bench for rom_arbiter (AW=12, DW=32, MAX_WAIT=4).
// The ROM model returns {addr, 8'h5A, addr} one cycle after rom_ce. Each step
// drives inputs on the falling edge and samples 2 ns later. At that point the
// combinational grants reflect the new inputs, and rvalid/rdata reflect the
// grant of the previous step.
module tb_rom_arbiter;

`ifdef ROM_ARB_STARVE_GUARD_EN
  localparam bit GUARD_EN = 1'b1;
`else
  localparam bit GUARD_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] dbg_owner;
  logic [3:0] dbg_wait;

  int checks   = 0;
  int failures = 0;

  rom_arbiter_if #(.AW(12), .DW(32)) bus ();

  rom_arbiter #(.AW(12), .DW(32), .MAX_WAIT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_owner (dbg_owner),
    .dbg_wait  (dbg_wait)
  );

  // ---------------------------------------------------------------------------
  // Clock / ROM model
  // ---------------------------------------------------------------------------
  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [11:0] a);
    return {a, 8'h5A, a};
  endfunction

  always @(posedge clk) begin
    if (bus.rom_ce) bus.rom_rdata <= rom_word(bus.rom_addr);
  end

  // ---------------------------------------------------------------------------
  // Driver / checker tasks
  // ---------------------------------------------------------------------------
  task automatic step(input logic ir, input logic [11:0] ia,
                      input logic lr, input logic [11:0] la);
    @(negedge clk);
    bus.if_req  = ir;
    bus.if_addr = ia;
    bus.ls_req  = lr;
    bus.ls_addr = la;
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  int   prev_kind;  // expected winner of the previous step: 0 none, 1 if, 2 ls
  logic exp_if;
  int   if_cnt, ls_cnt;

  initial begin
    rst           = 1'b1;
    bus.if_req    = 1'b1;
    bus.if_addr   = 12'h010;
    bus.ls_req    = 1'b0;
    bus.ls_addr   = 12'h000;
    bus.rom_rdata = '0;

    // Reset held with a fetch request: grants follow the request, no data.
    repeat (3) @(posedge clk);
    step(1'b1, 12'h010, 1'b0, 12'h000);
    chk("rst_if_rvalid", bus.if_rvalid, 1'b0);
    chk("rst_ls_rvalid", bus.ls_rvalid, 1'b0);
    chk("rst_if_rdata",  bus.if_rdata,  32'h0);
    chk("rst_ls_rdata",  bus.ls_rdata,  32'h0);
    chk("rst_if_gnt",    bus.if_gnt,    1'b1);
    chk("rst_rom_addr",  bus.rom_addr,  12'h010);
    chk("rst_owner",     dbg_owner,     2'd0);
    chk("rst_wait",      dbg_wait,      4'd0);

    // Release: no rvalid until the first post-reset edge.
    @(negedge clk);
    rst = 1'b0;
    #2;
    chk("rel_if_rvalid", bus.if_rvalid, 1'b0);

    // Fetch stream 0..3.
    step(1'b1, 12'h000, 1'b0, 12'h000);
    chk("first_if_rvalid", bus.if_rvalid, 1'b1);
    chk("first_if_rdata",  bus.if_rdata,  32'h0105A010);
    chk("fs0_if_gnt",      bus.if_gnt,    1'b1);
    chk("fs0_rom_addr",    bus.rom_addr,  12'h000);
    step(1'b1, 12'h001, 1'b0, 12'h000);
    chk("fs1_if_gnt",   bus.if_gnt,    1'b1);
    chk("fs1_if_rdata", bus.if_rdata,  32'h0005A000);
    chk("fs1_ls_rv",    bus.ls_rvalid, 1'b0);
    step(1'b1, 12'h002, 1'b0, 12'h000);
    chk("fs2_if_gnt",   bus.if_gnt,    1'b1);
    chk("fs2_if_rdata", bus.if_rdata,  32'h0015A001);
    step(1'b1, 12'h003, 1'b0, 12'h000);
    chk("fs3_if_gnt",   bus.if_gnt,    1'b1);
    chk("fs3_if_rdata", bus.if_rdata,  32'h0025A002);
    step(1'b0, 12'h000, 1'b0, 12'h000);
    chk("fs4_if_rvalid", bus.if_rvalid, 1'b1);
    chk("fs4_if_rdata",  bus.if_rdata,  32'h0035A003);
    chk("idle_if_gnt",   bus.if_gnt,    1'b0);
    chk("idle_rom_ce",   bus.rom_ce,    1'b0);
    chk("idle_rom_addr", bus.rom_addr,  12'h000);
    step(1'b0, 12'h000, 1'b0, 12'h000);
    chk("idle_if_rvalid", bus.if_rvalid, 1'b0);
    chk("idle_if_rdata",  bus.if_rdata,  32'h0);
    chk("idle_owner",     dbg_owner,     2'd0);

    // Collision with the guard idle: load wins.
    step(1'b1, 12'h004, 1'b1, 12'h100);
    chk("col_ls_gnt",   bus.ls_gnt,   1'b1);
    chk("col_if_gnt",   bus.if_gnt,   1'b0);
    chk("col_rom_addr", bus.rom_addr, 12'h100);
    chk("col_rom_ce",   bus.rom_ce,   1'b1);
    step(1'b0, 12'h000, 1'b0, 12'h000);
    chk("col_ls_rvalid", bus.ls_rvalid, 1'b1);
    chk("col_ls_rdata",  bus.ls_rdata,  32'h1005A100);
    chk("col_if_rvalid", bus.if_rvalid, 1'b0);
    chk("col_if_rdata",  bus.if_rdata,  32'h0);
    chk("col_wait",      dbg_wait,      GUARD_EN ? 4'd1 : 4'd0);

    // Both ports requesting continuously for 20 cycles. With the guard built,
    // the pattern is 4 load grants then 1 fetch grant. Without it, load wins
    // every cycle.
    step(1'b0, 12'h000, 1'b0, 12'h000);
    prev_kind = 0;
    if_cnt    = 0;
    ls_cnt    = 0;
    for (int k = 0; k < 20; k++) begin
      step(1'b1, 12'h020, 1'b1, 12'h200);
      exp_if = GUARD_EN && ((k % 5) == 4);
      chk("stv_if_gnt", bus.if_gnt, exp_if);
      chk("stv_ls_gnt", bus.ls_gnt, !exp_if);
      chk("stv_rom_addr", bus.rom_addr, exp_if ? 12'h020 : 12'h200);
      chk("stv_ls_rvalid", bus.ls_rvalid, prev_kind == 2);
      chk("stv_if_rvalid", bus.if_rvalid, prev_kind == 1);
      if (prev_kind == 2) chk("stv_ls_rdata", bus.ls_rdata, 32'h2005A200);
      if (prev_kind == 1) chk("stv_if_rdata", bus.if_rdata, 32'h0205A020);
      if (bus.if_gnt) if_cnt++;
      if (bus.ls_gnt) ls_cnt++;
      prev_kind = exp_if ? 1 : 2;
    end
    chk("stv_if_total", if_cnt, GUARD_EN ? 4  : 0);
    chk("stv_ls_total", ls_cnt, GUARD_EN ? 16 : 20);

    // Mid-transfer reset: load granted, then rst pulses while its data is out.
    step(1'b0, 12'h000, 1'b0, 12'h000);
    step(1'b1, 12'h030, 1'b1, 12'h123);
    chk("mr_ls_gnt", bus.ls_gnt, 1'b1);
    @(posedge clk);
    #2;
    chk("mr_ls_rvalid_pre", bus.ls_rvalid, 1'b1);
    chk("mr_ls_rdata_pre",  bus.ls_rdata,  32'h1235A123);
    chk("mr_wait_pre",      dbg_wait,      GUARD_EN ? 4'd1 : 4'd0);
    rst        = 1'b1;
    bus.if_req = 1'b0;
    bus.ls_req = 1'b0;
    #1;
    chk("mr_ls_rvalid", bus.ls_rvalid, 1'b0);
    chk("mr_ls_rdata",  bus.ls_rdata,  32'h0);
    chk("mr_owner",     dbg_owner,     2'd0);
    chk("mr_wait",      dbg_wait,      4'd0);
    #1;
    rst = 1'b0;
    step(1'b1, 12'h030, 1'b0, 12'h000);
    chk("mr_post_ls_rvalid", bus.ls_rvalid, 1'b0);
    chk("mr_post_if_gnt",    bus.if_gnt,    1'b1);
    chk("mr_post_wait",      dbg_wait,      4'd0);
    step(1'b0, 12'h000, 1'b0, 12'h000);
    chk("mr_post_if_rvalid", bus.if_rvalid, 1'b1);
    chk("mr_post_if_rdata",  bus.if_rdata,  32'h0305A030);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
